// File: rtl/tcs_pkg.sv
// Shared definitions for the tcs subtractor sequencer: default width and borrow rule.
package tcs_pkg;

  localparam int TCS_WIDTH = 2;
  localparam int TCS_MAX_W = 32;

  // A zero subtrahend makes the subtractor's carry meaningless, so it never borrows.
  function automatic logic calc_borrow(input logic [TCS_MAX_W-1:0] b, input logic carry);
    return (b != '0) & ~carry;
  endfunction

endpackage

// File: rtl/tcs_seq_if.sv
// Operand stream, subtractor hookup and result stream of the tcs sequencer.
interface tcs_seq_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] sub_sum;
  logic             sub_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;
  logic             out_zero;
  logic [CNT_W-1:0] borrow_cnt;

  modport slave (
    input  in_valid, in_a, in_b, sub_sum, sub_carry, out_ready,
    output in_ready, sub_a, sub_b, out_valid, out_diff, out_borrow, out_zero, borrow_cnt
  );

  modport master (
    output in_valid, in_a, in_b, sub_sum, sub_carry, out_ready,
    input  in_ready, sub_a, sub_b, out_valid, out_diff, out_borrow, out_zero, borrow_cnt
  );

endinterface

// File: rtl/tcs_fifo.sv
// Synchronous operand FIFO with an explicit occupancy count so full/empty never alias.
module tcs_fifo #(
  parameter int WIDTH2 = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH2-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [WIDTH2-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH2-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  // clr wins over both ports; a push into a full FIFO is dropped even if a pop frees a slot.
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tcs_seq.sv
// Sequencer feeding an external combinational subtractor: operand FIFO, head drive,
// registered difference/flags and a saturating borrow counter.
module tcs_seq
  import tcs_pkg::*;
#(
  parameter int WIDTH = TCS_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  tcs_seq_if.slave bus
);

  logic [2*WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               consume;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_diff_q;
  logic             out_borrow_q;
  logic             out_zero_q;
  logic [CNT_W-1:0] borrow_cnt_q;

  assign push    = bus.in_valid & ~full;
  assign pop     = ~empty & (~out_valid_q | bus.out_ready);
  assign consume = out_valid_q & bus.out_ready;

  tcs_fifo #(
    .WIDTH2 (2 * WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   ({bus.in_a, bus.in_b}),
    .full  (full),
    .empty (empty),
    .head  (fifo_head)
  );

  assign head_a = fifo_head[2*WIDTH-1:WIDTH];
  assign head_b = fifo_head[WIDTH-1:0];

  always_comb begin
    bus.sub_a = '0;
    bus.sub_b = '0;
    if (!empty) begin
      bus.sub_a = head_a;
      bus.sub_b = head_b;
    end
  end

  assign bus.in_ready = ~full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_diff_q   <= '0;
      out_borrow_q <= 1'b0;
      out_zero_q   <= 1'b0;
      borrow_cnt_q <= '0;
    end else if (clr) begin
      out_valid_q  <= 1'b0;
      borrow_cnt_q <= '0;
    end else begin
      // Counts the result leaving this cycle, before any reload replaces out_borrow_q.
      if (consume && out_borrow_q && (borrow_cnt_q != '1))
        borrow_cnt_q <= borrow_cnt_q + CNT_W'(1);
      if (pop) begin
        out_valid_q  <= 1'b1;
        out_diff_q   <= bus.sub_sum;
        out_borrow_q <= calc_borrow(TCS_MAX_W'(head_b), bus.sub_carry);
        out_zero_q   <= (bus.sub_sum == '0);
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_diff   = out_diff_q;
  assign bus.out_borrow = out_borrow_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.borrow_cnt = borrow_cnt_q;

endmodule
